// File: rtl/intr_ctrl.sv
// Interrupt collector: rising edges on src_intr become sticky pending bits,
// and the lowest-index enabled pending source is presented to the consumer as irq/irq_id.
module intr_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_intr,
  input  logic               en_wr,
  input  logic [NUM_SRC-1:0] en_wdata,
  output logic [NUM_SRC-1:0] en_q,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  input  logic               ack,
  input  logic [ID_W-1:0]    ack_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overrun,
  output logic               ack_err,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_SRC-1:0] en_d;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] ov_q, ov_d;
  logic               ack_err_q, ack_err_d;
  logic [NUM_SRC-1:0] edges;
  logic [NUM_SRC-1:0] masked;
  logic [NUM_SRC-1:0] clr_mask;
  logic [ID_W-1:0]    lowest;
  logic               any_req;
  logic               ack_ok;

  // Handshake: irq stays high with a stable irq_id until the cycle where
  // ack=1 and ack_id==irq_id; any other ack is rejected with an ack_err pulse.
  assign ack_ok   = ack && (state_q == ASSERT) && (ack_id == id_q);
  assign edges    = src_intr & ~prev_q;
  assign masked   = pend_q & en_q;
  assign clr_mask = ack_ok ? (NUM_SRC'(1) << id_q) : '0;

  always_comb begin
    lowest  = '0;
    any_req = |masked;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (masked[i]) lowest = ID_W'(i);
    end
  end

  // A simultaneous edge re-sets pending, but overrun is cleared by the ack.
  always_comb begin
    pend_d    = (pend_q & ~clr_mask) | edges;
    ov_d      = (ov_q | (edges & pend_q)) & ~clr_mask;
    en_d      = en_wr ? en_wdata : en_q;
    ack_err_d = ack && !ack_ok;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          id_d    = lowest;
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        if (ack_ok) state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      id_q      <= '0;
      en_q      <= '0;
      prev_q    <= '0;
      pend_q    <= '0;
      ov_q      <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      en_q      <= en_d;
      prev_q    <= src_intr;
      pend_q    <= pend_d;
      ov_q      <= ov_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign irq       = (state_q == ASSERT);
  assign irq_id    = id_q;
  assign pending   = pend_q;
  assign overrun   = ov_q;
  assign ack_err   = ack_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_intr_ctrl;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] src_intr;
  logic         en_wr;
  logic [N-1:0] en_wdata;
  logic [N-1:0] en_q;
  logic         irq;
  logic [W-1:0] irq_id;
  logic         ack;
  logic [W-1:0] ack_id;
  logic [N-1:0] pending;
  logic [N-1:0] overrun;
  logic         ack_err;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  intr_ctrl #(.NUM_SRC(N), .ID_W(W)) dut (
    .clk(clk), .rst(rst), .src_intr(src_intr), .en_wr(en_wr), .en_wdata(en_wdata),
    .en_q(en_q), .irq(irq), .irq_id(irq_id), .ack(ack), .ack_id(ack_id),
    .pending(pending), .overrun(overrun), .ack_err(ack_err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sets of pending/overrun sources, the currently presented
  // source (if any) and the number of quiet cycles still owed after an ack.
  bit         m_pend[N];
  bit         m_ov[N];
  bit         m_en[N];
  bit         m_prev[N];
  bit         m_busy;
  int         m_id;
  int         m_quiet;
  bit         m_err;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_ov[i] = 0; m_en[i] = 0; m_prev[i] = 0;
    end
    m_busy = 0; m_id = 0; m_quiet = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit valid;
    bit old_pend[N];
    bit old_en[N];
    int pick;
    if (rst) begin
      model_reset();
      return;
    end
    valid = ack && m_busy && (int'(ack_id) == m_id);
    for (int i = 0; i < N; i++) begin
      old_pend[i] = m_pend[i];
      old_en[i]   = m_en[i];
    end
    for (int i = 0; i < N; i++) begin
      bit rise;
      rise = src_intr[i] && !m_prev[i];
      if (rise && old_pend[i]) m_ov[i] = 1;
      if (valid && i == m_id) begin
        m_pend[i] = 0;
        m_ov[i]   = 0;
      end
      if (rise) m_pend[i] = 1;
      m_prev[i] = src_intr[i];
      if (en_wr) m_en[i] = en_wdata[i];
    end
    m_err = ack && !valid;
    if (m_busy) begin
      if (valid) begin
        m_busy  = 0;
        m_quiet = 1;
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else begin
      pick = -1;
      for (int i = N - 1; i >= 0; i--)
        if (old_pend[i] && old_en[i]) pick = i;
      if (pick >= 0) begin
        m_busy = 1;
        m_id   = pick;
      end
    end
  endtask

  function automatic logic [N-1:0] pack(input bit v[N]);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[i];
    return r;
  endfunction

  // compare process: model advances on each edge, outputs checked 1 time unit later
  always @(posedge clk) begin
    model_step();
    #1;
    check("irq", 32'(irq), 32'(m_busy));
    if (m_busy) check("irq_id", 32'(irq_id), 32'(m_id));
    check("pending", 32'(pending), 32'(pack(m_pend)));
    check("overrun", 32'(overrun), 32'(pack(m_ov)));
    check("en_q", 32'(en_q), 32'(pack(m_en)));
    check("ack_err", 32'(ack_err), 32'(m_err));
  end

  // driver: advance one cycle, then inputs may change safely at posedge+2
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    src_intr = '0; en_wr = 0; en_wdata = '0; ack = 0; ack_id = '0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    cyc(); cyc();
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_irq_id", 32'(irq_id), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_en", 32'(en_q), 32'd0);
    rst = 0;

    // single source, full latency
    en_wr = 1; en_wdata = 8'hFF;
    cyc();
    en_wr = 0; src_intr = 8'h20;
    cyc();
    check("t1_pend", 32'(pending), 32'h20);
    check("t1_irq_e0", 32'(irq), 32'd0);
    src_intr = '0;
    cyc();
    check("t1_irq", 32'(irq), 32'd1);
    check("t1_id", 32'(irq_id), 32'd5);
    cyc(); cyc();
    ack = 1; ack_id = 3'd5;
    cyc();
    check("t1_irq_ack", 32'(irq), 32'd0);
    check("t1_pend_ack", 32'(pending), 32'd0);
    ack = 0;
    cyc(); cyc();

    // priority and gap
    src_intr = 8'h44;
    cyc();
    src_intr = '0;
    cyc();
    check("t2_id_first", 32'(irq_id), 32'd2);
    check("t2_irq_first", 32'(irq), 32'd1);
    ack = 1; ack_id = 3'd2;
    cyc();
    ack = 0;
    check("t2_gap", 32'(irq), 32'd0);
    cyc();
    check("t2_idle", 32'(irq), 32'd0);
    cyc();
    check("t2_irq_second", 32'(irq), 32'd1);
    check("t2_id_second", 32'(irq_id), 32'd6);
    ack = 1; ack_id = 3'd6;
    cyc();
    ack = 0;
    cyc(); cyc();

    // disabled source stays pending until enabled
    en_wr = 1; en_wdata = 8'h00;
    cyc();
    en_wr = 0; src_intr = 8'h08;
    cyc();
    src_intr = '0;
    cyc(); cyc();
    check("t3_pend", 32'(pending), 32'h08);
    check("t3_no_irq", 32'(irq), 32'd0);
    en_wr = 1; en_wdata = 8'h08;
    cyc();
    en_wr = 0;
    check("t3_irq_w", 32'(irq), 32'd0);
    cyc();
    check("t3_irq", 32'(irq), 32'd1);
    check("t3_id", 32'(irq_id), 32'd3);
    ack = 1; ack_id = 3'd3;
    cyc();
    ack = 0;
    cyc(); cyc();

    // wrong-id ack and overrun
    en_wr = 1; en_wdata = 8'hFF;
    cyc();
    en_wr = 0; src_intr = 8'h10;
    cyc();
    src_intr = '0;
    cyc();
    check("t4_id", 32'(irq_id), 32'd4);
    ack = 1; ack_id = 3'd1;
    cyc();
    ack = 0;
    check("t4_ack_err", 32'(ack_err), 32'd1);
    check("t4_irq_held", 32'(irq), 32'd1);
    check("t4_pend_held", 32'(pending), 32'h10);
    cyc();
    check("t4_ack_err_pulse", 32'(ack_err), 32'd0);
    src_intr = 8'h10;
    cyc();
    src_intr = '0;
    check("t4_overrun", 32'(overrun), 32'h10);
    ack = 1; ack_id = 3'd4;
    cyc();
    ack = 0;
    check("t4_pend_clr", 32'(pending), 32'd0);
    check("t4_ov_clr", 32'(overrun), 32'd0);
    check("t4_irq_clr", 32'(irq), 32'd0);
    cyc(); cyc();

    // edge coincident with ack, then reset while presenting
    src_intr = 8'h01;
    cyc();
    src_intr = '0;
    cyc();
    check("t5_id", 32'(irq_id), 32'd0);
    src_intr = 8'h01; ack = 1; ack_id = 3'd0;
    cyc();
    src_intr = '0; ack = 0;
    check("t5_pend_kept", 32'(pending), 32'h01);
    check("t5_ov_clear", 32'(overrun), 32'd0);
    check("t5_irq_gap", 32'(irq), 32'd0);
    cyc();
    cyc();
    check("t5_reassert", 32'(irq), 32'd1);
    check("t5_reassert_id", 32'(irq_id), 32'd0);
    rst = 1;
    cyc();
    rst = 0;
    check("t5_rst_irq", 32'(irq), 32'd0);
    check("t5_rst_pend", 32'(pending), 32'd0);
    check("t5_rst_en", 32'(en_q), 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      src_intr = '0;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 99) < 15) src_intr[i] = 1'b1;
      en_wr    = ($urandom_range(0, 99) < 5);
      en_wdata = N'($urandom);
      ack = 0;
      ack_id = W'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 30) begin
        ack = 1;
        if (m_busy && $urandom_range(0, 99) < 70) ack_id = W'(m_id);
      end
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 0;
    idle_inputs();
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
